keypad_scan: RTL
================

# keypad_scan

Scanner and debouncer for the 4x4 matrix keypad of the charging-station front panel. It drives the keypad rows, samples the columns and debounces contacts. It presents each accepted press to the charge controller as a 4-bit code `key_value` with a level strobe `EN`. The controller acts on the rising edge of `EN` and decodes `key_value` as follows: 0-2, 4-6, 8-10 are digits 1-9; 12 is digit 0; 3 is start; 7 is clear; 11 is confirm; 13-15 are unused.

## Interface
- `SCAN_DIV`, 4: CLK cycles per row window; legal values are 3 and above.
- `DEBOUNCE`, 3: consecutive matching row-window samples needed to accept a press or a release; legal values are 1-15.
- `CLK` in 1: single system clock; every register is clocked on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `col_in` in 4: keypad columns, active low with external pull-ups; asynchronous to CLK.
- `row_out` out 4: row drive, active low, one-cold.
- `key_value` out 4: code of the key, equal to row*4 + col; stable while `EN`=1 and held after release.
- `EN` out 1: high while a debounced key is held.

## Operation
- `col_in` passes through a 2-flop synchronizer to give `col_s`.
- Row-window timing:
  - Divider `div` counts 0..SCAN_DIV-1.
  - A tick occurs in the cycle where `div`=SCAN_DIV-1.
  - Columns are sampled only on ticks (`col_s`), which gives at least 2 cycles of settling after a row change.
- State SCAN:
  - `row_out` is 0 in the bit of the current row `r`.
  - On a tick, if `col_s`=4'b1111, `r` advances 0→1→2→3→0.
  - Otherwise the block latches `r` and `c`, where `c` is the lowest-index low column, sets `cnt`=1 and goes to DEB. If DEBOUNCE=1 it goes straight to PRESSED.
- State DEB:
  - `row_out` is held on the latched row.
  - On a tick, if `col_s[c]`=0, `cnt`++. When `cnt` reaches DEBOUNCE, the block loads `key_value`={r,c}, sets `EN`=1 and goes to PRESSED.
  - On a tick with `col_s[c]`=1, it returns to SCAN with the same row and `EN` stays 0.
- State PRESSED:
  - `EN`=1 and `row_out` is held.
  - On a tick, if `col_s[c]`=1, `rcnt`++; otherwise `rcnt` is set to 0.
  - When `rcnt` reaches DEBOUNCE, the block clears `EN`, sets `rcnt`=0 and returns to SCAN with the row advanced.
  - Other keys are ignored; there is no rollover.
- Simultaneous keys:
  - In the same row, the lowest column wins.
  - Across rows, the first row reached in the scan wins.
  - A second key held when the first is released is accepted as a new press after the normal debounce.
- `key_value` changes only on entry to PRESSED.

## Timing
- Reset values:
  - `row_out`=4'b1110, `key_value`=4'hF, `EN`=0.
  - State is SCAN, `r`=0, `div`=0, `cnt`=0, `rcnt`=0, synchronizer flops = 4'b1111.
- `RST` mid-operation, including while `EN`=1, forces the reset values at the next edge. No release strobe is generated.
- Press latency: `EN` rises at the edge after the DEBOUNCE-th consecutive matching tick. That is (DEBOUNCE-1)·SCAN_DIV+1 cycles after the detecting tick, plus 2 synchronizer cycles from the pin.
- Release latency: `EN` falls at the edge after the DEBOUNCE-th consecutive released tick.
- Minimum `EN` high time is DEBOUNCE·SCAN_DIV cycles. Minimum `EN` low time between presses is 1 cycle plus scan time.
- `key_value` is valid in the same cycle `EN` rises.

## Structure
- Package `keypad_pkg` holds:
  - the state enum (SCAN, DEB, PRESSED);
  - key constants: KEY_START=3, KEY_CLEAR=7, KEY_CONFIRM=11, KEY_ZERO=12, KEY_NONE=15;
  - the row reset pattern 4'b1110.
- One sub-module, `keypad_sync`: a 4-bit 2-flop synchronizer with reset value 4'b1111.
- The top level contains the divider, row counter, FSM and debounce counters.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3.
- Clean press of row 0, col 3 (start) held 100 cycles → `key_value`=3 and `EN`=1 within 9 cycles of the detecting tick. `EN` falls 12-16 cycles after release. `row_out` stays 4'b1110 while held.
- Bounce: col 3 of row 2 toggles every 4 cycles for 40 cycles, then is held low → no `EN` during bounce. Then `key_value`=11 and `EN` rises exactly once.
- Row 1, cols 1 and 2 pressed together → `key_value`=5.
- Row 0 col 0 held, then row 3 col 0 pressed, then row 0 released → first `key_value`=0. After release, `EN` drops, then rises with `key_value`=12.
- Assert `RST` for 1 cycle while `EN`=1 → next cycle `EN`=0, `key_value`=4'hF, `row_out`=4'b1110.
- Glitch of 1 row window (one tick low) → no `EN`, and the scan continues from the same row.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key codes and helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEB, PRESSED} kp_state_t;

    localparam logic [3:0] KEY_START   = 4'd3;
    localparam logic [3:0] KEY_CLEAR   = 4'd7;
    localparam logic [3:0] KEY_CONFIRM = 4'd11;
    localparam logic [3:0] KEY_ZERO    = 4'd12;
    localparam logic [3:0] KEY_NONE    = 4'd15;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Lowest-index column pulled low wins when several keys share a row.
    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << r;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix and key-report signals
interface keypad_scan_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_value;
    logic       EN;

    modport master (
        input  col_in,
        output row_out,
        output key_value,
        output EN
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_value,
        input  EN
    );
endinterface

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - 4-bit two-flop synchronizer, idles high like the pulled-up columns
module keypad_sync (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner with press/release debounce
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic           CLK,
    input  logic           RST,
    keypad_scan_if.master  kp
);
    localparam int             DW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_N    = 4'(DEBOUNCE);

    logic [3:0]    col_s;
    logic [DW-1:0] div;
    logic          tick;
    kp_state_t     state;
    logic [1:0]    r;
    logic [1:0]    c;
    logic [3:0]    cnt;
    logic [3:0]    rcnt;
    logic [3:0]    row_q;
    logic [3:0]    key_q;
    logic          en_q;

    keypad_sync u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (kp.col_in),
        .q   (col_s)
    );

    assign tick         = (div == DIV_LAST);
    assign kp.row_out   = row_q;
    assign kp.key_value = key_q;
    assign kp.EN        = en_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SCAN;
            div   <= '0;
            r     <= 2'd0;
            c     <= 2'd0;
            cnt   <= 4'd0;
            rcnt  <= 4'd0;
            row_q <= ROW_RESET;
            key_q <= KEY_NONE;
            en_q  <= 1'b0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            // Columns are only trusted at the end of a row window, after settling.
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (col_s == 4'hF) begin
                            r     <= r + 2'd1;
                            row_q <= row_drive(r + 2'd1);
                        end else begin
                            c   <= lowest_low(col_s);
                            cnt <= 4'd1;
                            if (DEB_N == 4'd1) begin
                                key_q <= {r, lowest_low(col_s)};
                                en_q  <= 1'b1;
                                state <= PRESSED;
                            end else begin
                                state <= DEB;
                            end
                        end
                    end
                    DEB: begin
                        if (!col_s[c]) begin
                            if (cnt == DEB_N - 4'd1) begin
                                key_q <= {r, c};
                                en_q  <= 1'b1;
                                cnt   <= 4'd0;
                                state <= PRESSED;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            // A bounce keeps the row so the key is re-examined next window.
                            cnt   <= 4'd0;
                            state <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (col_s[c]) begin
                            if (rcnt == DEB_N - 4'd1) begin
                                en_q  <= 1'b0;
                                rcnt  <= 4'd0;
                                r     <= r + 2'd1;
                                row_q <= row_drive(r + 2'd1);
                                state <= SCAN;
                            end else begin
                                rcnt <= rcnt + 4'd1;
                            end
                        end else begin
                            rcnt <= 4'd0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
endmodule
